// File: rtl/axis_desc_framer.sv
// rtl/axis_desc_framer.sv - descriptor-driven framer turning DMA read words into a keyed AXI-Stream
//
// Purpose: takes one command per descriptor and the word-aligned read data that
//   belongs to it. Each read word is forwarded as one output beat. The beat carries
//   a contiguous tkeep and a tlast on the final word of an EOP descriptor. tuser holds
//   the destination offset latched by the command that opened the packet.
// Ports:
//   aclk, aresetn             clock, asynchronous active-low reset
//   cmd_offset/len/eop/dst_off command fields; cmd_valid/cmd_ready handshake
//   cmd_done                  1-cycle pulse once a command is fully forwarded
//   rd_tdata/tlast/tvalid     read-engine stream in; rd_tready back-pressure
//   m_tdata/tkeep/tlast/tuser output stream; m_tvalid/m_tready handshake
//   err                       sticky rd_tlast mismatch flag
//   err_len                   1-cycle pulse for a dropped zero-length command
module axis_desc_framer #(
  parameter int    LEN_WIDTH         = 16,
  parameter string INPUT_BIG_ENDIAN  = "TRUE",
  parameter string OUTPUT_BIG_ENDIAN = "TRUE"
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [1:0]           cmd_offset,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_eop,
  input  logic [1:0]           cmd_dst_off,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic                 cmd_done,
  input  logic [31:0]          rd_tdata,
  input  logic                 rd_tlast,
  input  logic                 rd_tvalid,
  output logic                 rd_tready,
  output logic [31:0]          m_tdata,
  output logic [3:0]           m_tkeep,
  output logic                 m_tlast,
  output logic [1:0]           m_tuser,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 err,
  output logic                 err_len
);
  localparam int CW         = LEN_WIDTH + 1;
  localparam bit SWAP_BYTES = (INPUT_BIG_ENDIAN != OUTPUT_BIG_ENDIAN);
  localparam bit KEEP_LSB0  = (OUTPUT_BIG_ENDIAN == "FALSE");

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] word_cnt, word_total;
  logic [3:0]    first_be, last_be;
  logic          cur_eop, pkt_open;
  logic [1:0]    pkt_user;

  logic          skid_valid;
  logic [31:0]   skid_tdata;
  logic [3:0]    skid_tkeep;
  logic          skid_tlast;
  logic [1:0]    skid_tuser;

  logic          cmd_fire, cmd_zero, rd_fire, final_word, out_load;
  logic [CW-1:0] cmd_words;
  logic [1:0]    cmd_end_byte;
  logic [3:0]    beat_be, in_tkeep;
  logic [31:0]   in_tdata;
  logic          in_tlast;

  assign cmd_fire     = cmd_valid && cmd_ready;
  assign cmd_zero     = (cmd_len == '0);
  assign cmd_words    = (CW'(cmd_len) + CW'(cmd_offset) + CW'(3)) >> 2;
  // Byte lane of the last valid byte, modulo the word size.
  assign cmd_end_byte = cmd_offset + cmd_len[1:0] - 2'd1;
  assign rd_fire      = rd_tvalid && rd_tready;
  assign final_word   = (word_cnt == word_total - CW'(1));
  assign out_load     = !m_tvalid || m_tready;

  // Masks are kept in big-endian view (bit3 = byte0); a single-word command
  // naturally gets first & last.
  always_comb begin
    beat_be = 4'b1111;
    if (word_cnt == '0) beat_be = beat_be & first_be;
    if (final_word)     beat_be = beat_be & last_be;
  end

  assign in_tkeep = KEEP_LSB0 ? {beat_be[0], beat_be[1], beat_be[2], beat_be[3]} : beat_be;
  assign in_tdata = SWAP_BYTES ? {rd_tdata[7:0], rd_tdata[15:8], rd_tdata[23:16], rd_tdata[31:24]}
                               : rd_tdata;
  assign in_tlast = cur_eop && final_word;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rd_tready = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_zero) state_nxt = S_RUN;
      end
      S_RUN: begin
        // Skid occupied means both buffer entries are in use.
        rd_tready = !skid_valid;
        if (rd_tvalid && !skid_valid && final_word) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_cnt   <= '0;
      word_total <= '0;
      first_be   <= 4'b0000;
      last_be    <= 4'b0000;
      cur_eop    <= 1'b0;
      pkt_open   <= 1'b0;
      pkt_user   <= 2'b00;
      cmd_done   <= 1'b0;
      err_len    <= 1'b0;
      err        <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      err_len  <= 1'b0;
      if (cmd_fire) begin
        if (cmd_zero) begin
          cmd_done <= 1'b1;
          err_len  <= 1'b1;
        end else begin
          word_cnt   <= '0;
          word_total <= cmd_words;
          first_be   <= 4'b1111 >> cmd_offset;
          last_be    <= 4'b1111 << (2'd3 - cmd_end_byte);
          cur_eop    <= cmd_eop;
          if (!pkt_open) begin
            pkt_user <= cmd_dst_off;
            pkt_open <= 1'b1;
          end
        end
      end
      if (rd_fire) begin
        word_cnt <= word_cnt + CW'(1);
        // The word count alone decides the command end; rd_tlast is only audited.
        if (rd_tlast != final_word) err <= 1'b1;
        if (final_word) begin
          cmd_done <= 1'b1;
          if (cur_eop) pkt_open <= 1'b0;
        end
      end
    end
  end

  // Two-entry buffer: the m_* registers are the head, the skid register the tail.
  // tuser travels with each beat so a new packet's offset never alters a stalled beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tkeep    <= 4'b0000;
      m_tlast    <= 1'b0;
      m_tuser    <= 2'b00;
      skid_valid <= 1'b0;
      skid_tdata <= '0;
      skid_tkeep <= 4'b0000;
      skid_tlast <= 1'b0;
      skid_tuser <= 2'b00;
    end else if (out_load) begin
      if (skid_valid) begin
        m_tvalid   <= 1'b1;
        m_tdata    <= skid_tdata;
        m_tkeep    <= skid_tkeep;
        m_tlast    <= skid_tlast;
        m_tuser    <= skid_tuser;
        skid_valid <= 1'b0;
      end else begin
        m_tvalid <= rd_fire;
        if (rd_fire) begin
          m_tdata <= in_tdata;
          m_tkeep <= in_tkeep;
          m_tlast <= in_tlast;
          m_tuser <= pkt_user;
        end
      end
    end else if (rd_fire) begin
      skid_valid <= 1'b1;
      skid_tdata <= in_tdata;
      skid_tkeep <= in_tkeep;
      skid_tlast <= in_tlast;
      skid_tuser <= pkt_user;
    end
  end
endmodule

// File: tb/tb_axis_desc_framer.sv
// tb/tb_axis_desc_framer.sv - scoreboard bench for axis_desc_framer
module tb_axis_desc_framer;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  cmd_offset = 2'd0;
  logic [15:0] cmd_len = 16'd0;
  logic        cmd_eop = 1'b0;
  logic [1:0]  cmd_dst_off = 2'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, cmd_done;
  logic [31:0] rd_tdata = 32'd0;
  logic        rd_tlast = 1'b0;
  logic        rd_tvalid = 1'b0;
  logic        rd_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [1:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic        err, err_len;

  axis_desc_framer dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_offset(cmd_offset), .cmd_len(cmd_len), .cmd_eop(cmd_eop), .cmd_dst_off(cmd_dst_off),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .rd_tdata(rd_tdata), .rd_tlast(rd_tlast), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .err(err), .err_len(err_len)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; logic [1:0] user; } beat_t;
  typedef struct { logic [31:0] data; logic last; } word_t;
  typedef struct { int off; int len; bit eop; int dst; int bad; } cmd_t;

  beat_t exp_q[$];
  word_t rd_q[$];
  cmd_t  cmd_q[$];

  int checks = 0, errors = 0;
  int done_seen = 0, done_exp = 0, errlen_seen = 0, errlen_exp = 0;
  int cyc = 0, ready_mode = 1, rd_gap = 0;
  int first_cyc = 0, last_cyc = 0, beat_cnt = 0;
  int tb_user = 0;
  bit tb_open = 0, err_exp = 0, cmds_busy = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(int off, int len, bit eop, int dst, int bad);
    cmd_t c;
    c.off = off; c.len = len; c.eop = eop; c.dst = dst; c.bad = bad;
    cmd_q.push_back(c);
  endtask

  // Reference: each read word i covers stream bytes 4i..4i+3; a byte is kept when it
  // falls inside [off, off+len).
  task automatic model(cmd_t c);
    int nw, p;
    word_t w;
    beat_t b;
    done_exp++;
    if (c.len == 0) begin
      errlen_exp++;
      return;
    end
    if (!tb_open) begin
      tb_user = c.dst;
      tb_open = 1;
    end
    nw = (c.off + c.len + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w.data = $urandom;
      w.last = (i == nw - 1);
      if (i == c.bad) begin
        w.last = !w.last;
        err_exp = 1;
      end
      b.data = w.data;
      b.keep = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        p = 4 * i + k;
        if (p >= c.off && p < c.off + c.len) b.keep[3-k] = 1'b1;
      end
      b.last = c.eop && (i == nw - 1);
      b.user = tb_user[1:0];
      rd_q.push_back(w);
      exp_q.push_back(b);
    end
    if (c.eop) tb_open = 0;
  endtask

  task automatic drive_cmds();
    cmd_t c;
    int t;
    while (cmd_q.size() > 0) begin
      c = cmd_q.pop_front();
      model(c);
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      cmd_offset  = c.off[1:0];
      cmd_len     = c.len[15:0];
      cmd_eop     = c.eop;
      cmd_dst_off = c.dst[1:0];
      cmd_valid   = 1'b1;
      t = 0;
      forever begin
        @(negedge aclk);
        if (cmd_ready) break;
        t++;
        if (t > 3000) begin
          chk("cmd_ready_timeout", 0, 1);
          break;
        end
      end
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drive_rd();
    word_t w;
    int t, idle;
    idle = 0;
    while (cmds_busy || rd_q.size() > 0) begin
      if (rd_q.size() == 0) begin
        @(posedge aclk); #1;
        idle++;
        if (idle > 20000) begin
          chk("rd_idle_timeout", 0, 1);
          break;
        end
        continue;
      end
      w = rd_q.pop_front();
      if (rd_gap != 0) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      rd_tdata  = w.data;
      rd_tlast  = w.last;
      rd_tvalid = 1'b1;
      t = 0;
      forever begin
        @(negedge aclk);
        if (rd_tready) break;
        t++;
        if (t > 3000) begin
          chk("rd_tready_timeout", 0, 1);
          break;
        end
      end
      @(posedge aclk); #1;
      rd_tvalid = 1'b0;
    end
  endtask

  task automatic run_phase(string tag);
    int t;
    cmds_busy = 1;
    fork
      begin
        drive_cmds();
        cmds_busy = 0;
      end
      drive_rd();
    join
    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      @(posedge aclk); #1;
      t++;
    end
    if (exp_q.size() > 0) chk({tag, "_drain"}, exp_q.size(), 0);
    repeat (3) begin @(posedge aclk); #1; end
    chk({tag, "_cmd_done_count"}, done_seen, done_exp);
    chk({tag, "_err_len_count"}, errlen_seen, errlen_exp);
    chk({tag, "_err"}, err, err_exp);
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (ready_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        2:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (cmd_done) done_seen++;
        if (err_len) errlen_seen++;
        if (m_tvalid && m_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat actual data=%h keep=%b last=%b required none", m_tdata, m_tkeep, m_tlast);
          end else begin
            b = exp_q.pop_front();
            if (m_tdata !== b.data || m_tkeep !== b.keep || m_tlast !== b.last || m_tuser !== b.user) begin
              errors++;
              $display("FAIL beat actual data=%h keep=%b last=%b user=%0d required data=%h keep=%b last=%b user=%0d",
                       m_tdata, m_tkeep, m_tlast, m_tuser, b.data, b.keep, b.last, b.user);
            end
          end
          beat_cnt++;
          if (beat_cnt == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_m_tvalid", m_tvalid, 0);
    chk("reset_m_tkeep", m_tkeep, 0);
    chk("reset_m_tdata", m_tdata, 0);
    chk("reset_m_tuser", m_tuser, 0);
    chk("reset_cmd_done", cmd_done, 0);
    chk("reset_err", err, 0);
    chk("reset_err_len", err_len, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rd_tready", rd_tready, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    ready_mode = 1;
    rd_gap = 0;
    add(1, 6, 1, 0, -1);
    run_phase("t1");
    add(3, 1, 1, 0, -1);
    run_phase("t2");
    add(2, 2, 0, 2, -1);
    add(0, 5, 1, 1, -1);
    run_phase("t3");

    ready_mode = 2;
    add(0, 64, 1, 3, -1);
    run_phase("t4_toggle");
    ready_mode = 1;
    beat_cnt = 0;
    add(0, 64, 1, 1, -1);
    run_phase("t4_steady");
    chk("t4_beat_count", beat_cnt, 16);
    chk("t4_full_rate_span", last_cyc - first_cyc, 15);

    add(0, 8, 1, 2, 0);
    run_phase("t5_bad_tlast");
    add(1, 3, 1, 0, -1);
    run_phase("t5_after");

    add(0, 0, 1, 3, -1);
    add(1, 3, 0, 2, -1);
    add(0, 0, 1, 1, -1);
    add(0, 4, 1, 3, -1);
    run_phase("t6_zero_len");

    rd_gap = 1;
    ready_mode = 3;
    for (int i = 0; i < 40; i++) begin
      add($urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40),
          1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
    end
    add(0, 1, 1, 0, -1);
    run_phase("random");

    rd_gap = 0;
    ready_mode = 0;
    @(posedge aclk); #1;
    cmd_offset = 2'd0; cmd_len = 16'd16; cmd_eop = 1'b1; cmd_dst_off = 2'd3; cmd_valid = 1'b1;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    rd_tvalid = 1'b1; rd_tlast = 1'b0; rd_tdata = $urandom;
    @(posedge aclk); #1;
    rd_tdata = $urandom;
    @(posedge aclk); #1;
    rd_tvalid = 1'b0;
    chk("midpkt_m_tvalid", m_tvalid, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_reset_m_tvalid", m_tvalid, 0);
    chk("async_reset_m_tkeep", m_tkeep, 0);
    chk("async_reset_err", err, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    exp_q.delete();
    rd_q.delete();
    tb_open = 0;
    err_exp = 0;
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_rd_tready", rd_tready, 0);
    ready_mode = 1;
    add(2, 7, 1, 1, -1);
    run_phase("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
